lcd_line_fetch: RTL and testbench

Pixel source stage directly upstream of the LCD timing driver. It fetches display lines from a framebuffer over a burst read port into a ping-pong pair of line buffers. It returns pixel_data/pixel_valid in the same cycle as the driver's pixel_hpos/pixel_vpos, so the driver's combinational output path needs no extra latency. Line k is displayed from one buffer while line k+1 is fetched into the other.

---
 rtl/lcd_line_fetch_pkg.sv | 6 +
 rtl/lcd_line_bank.sv | 21 ++
 rtl/lcd_line_fetch.sv | 122 ++++++++++++
 tb/tb_lcd_line_fetch.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_line_fetch_pkg.sv
// lcd_line_fetch_pkg: shared display widths and line-fetch FSM encoding
package lcd_line_fetch_pkg;
  localparam int RGB_W = 24;
  localparam int TIM_W = 12;
  typedef enum logic [1:0] {IDLE, REQ, DATA} fetch_state_t;
endpackage

// File: rtl/lcd_line_bank.sv
// lcd_line_bank: ping-pong pair of line buffers, sync write, async read
module lcd_line_bank
  import lcd_line_fetch_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic             wr_bank,
  input  logic [AW-1:0]    wr_addr,
  input  logic [RGB_W-1:0] wr_data,
  input  logic             rd_bank,
  input  logic [AW-1:0]    rd_addr,
  output logic [RGB_W-1:0] rd_data
);
  logic [RGB_W-1:0] mem [2][DEPTH];
  always_ff @(posedge clk)
    if (we) mem[wr_bank][wr_addr] <= wr_data;
  assign rd_data = mem[rd_bank][rd_addr];
endmodule

// File: rtl/lcd_line_fetch.sv
// lcd_line_fetch: fetches display lines into ping-pong buffers, serves pixels with zero latency
module lcd_line_fetch
  import lcd_line_fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_MAX = 1024
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] fb_base,
  input  logic [TIM_W-1:0]  h_disp,
  input  logic [TIM_W-1:0]  v_disp,
  input  logic              lcd_vs,
  input  logic              lcd_en,
  input  logic [TIM_W-1:0]  pixel_hpos,
  input  logic [TIM_W-1:0]  pixel_vpos,
  output logic              pixel_valid,
  output logic [RGB_W-1:0]  pixel_data,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [TIM_W-1:0]  rd_len,
  input  logic              rd_ack,
  input  logic              rd_valid,
  input  logic [RGB_W-1:0]  rd_data,
  output logic              underrun,
  input  logic              clr_underrun
);
  localparam int AW = $clog2(LINE_MAX);
  fetch_state_t state;
  logic vs_q, en_q, row_par, fetch_pending, abort;
  logic [1:0] ready, rdy_set, rdy_clr;
  logic [TIM_W-1:0] next_line, wr_ptr, row_next;
  logic [ADDR_W-1:0] line_addr;
  logic frame_start, line_start, line_end, beat, last_beat;
  logic [RGB_W-1:0] bank_q;
  assign frame_start = vs_q & ~lcd_vs;
  assign line_start = lcd_en & ~en_q;
  assign line_end = en_q & ~lcd_en;
  assign row_next = pixel_vpos + TIM_W'(1);
  assign beat = state == DATA && rd_valid;
  assign last_beat = beat && wr_ptr == h_disp - TIM_W'(1);
  // a burst overtaken by a frame start is drained but never marks its bank ready
  always_comb begin
    rdy_set = '0;
    rdy_clr = '0;
    if (last_beat && !abort) rdy_set[next_line[0]] = 1'b1;
    if (line_start) rdy_clr[row_next[0]] = 1'b1;
    if (line_end) rdy_clr[row_par] = 1'b1;
    if (frame_start) rdy_clr = 2'b11;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      vs_q <= 1'b0;
      en_q <= 1'b0;
      row_par <= 1'b0;
      fetch_pending <= 1'b0;
      abort <= 1'b0;
      ready <= '0;
      next_line <= '0;
      wr_ptr <= '0;
      line_addr <= '0;
      rd_req <= 1'b0;
      rd_addr <= '0;
      rd_len <= '0;
      underrun <= 1'b0;
    end else begin
      vs_q <= lcd_vs;
      en_q <= lcd_en;
      if (line_start) row_par <= pixel_vpos[0];
      ready <= (ready | rdy_set) & ~rdy_clr;
      underrun <= !clr_underrun && (underrun || (lcd_en && !ready[pixel_vpos[0]]));
      case (state)
        IDLE:
          if (fetch_pending && !frame_start) begin
            rd_req <= 1'b1;
            rd_addr <= line_addr;
            rd_len <= h_disp;
            fetch_pending <= 1'b0;
            abort <= 1'b0;
            state <= REQ;
          end
        REQ:
          if (rd_ack) begin
            rd_req <= 1'b0;
            wr_ptr <= '0;
            state <= DATA;
          end
        DATA:
          if (beat) begin
            wr_ptr <= wr_ptr + TIM_W'(1);
            if (last_beat) begin
              state <= IDLE;
              if (!abort) begin
                line_addr <= line_addr + ADDR_W'(h_disp);
                next_line <= next_line + TIM_W'(1);
              end
            end
          end
        default: state <= IDLE;
      endcase
      if (line_start && row_next < v_disp) fetch_pending <= 1'b1;
      if (frame_start) begin
        fetch_pending <= 1'b1;
        next_line <= '0;
        line_addr <= fb_base;
        if (state != IDLE && !last_beat) abort <= 1'b1;
      end
    end
  lcd_line_bank #(.DEPTH(LINE_MAX)) u_bank (
    .clk(clk),
    .we(beat),
    .wr_bank(next_line[0]),
    .wr_addr(wr_ptr[AW-1:0]),
    .wr_data(rd_data),
    .rd_bank(pixel_vpos[0]),
    .rd_addr(pixel_hpos[AW-1:0]),
    .rd_data(bank_q)
  );
  assign pixel_valid = lcd_en & ready[pixel_vpos[0]];
  assign pixel_data = (pixel_valid && pixel_hpos < TIM_W'(LINE_MAX)) ? bank_q : '0;
endmodule

// File: tb/tb_lcd_line_fetch.sv
// tb_lcd_line_fetch: randomized scoreboard bench with a line-level framebuffer model
module tb_lcd_line_fetch;
  logic clk = 1'b0, rstn = 1'b0;
  logic [31:0] fb_base = 32'h100;
  logic [11:0] h_disp, v_disp, pixel_hpos = '0, pixel_vpos = '0, rd_len;
  logic lcd_vs = 1'b1, lcd_en = 1'b0, clr_underrun = 1'b0;
  logic pixel_valid, rd_req, rd_ack, rd_valid, underrun;
  logic [23:0] pixel_data, rd_data;
  logic [31:0] rd_addr;
  int h = 8, v = 4;
  assign h_disp = 12'(h);
  assign v_disp = 12'(v);
  always #5 clk = ~clk;

  lcd_line_fetch #(.ADDR_W(32), .LINE_MAX(1024)) dut (
    .clk(clk), .rstn(rstn), .fb_base(fb_base), .h_disp(h_disp), .v_disp(v_disp),
    .lcd_vs(lcd_vs), .lcd_en(lcd_en), .pixel_hpos(pixel_hpos), .pixel_vpos(pixel_vpos),
    .pixel_valid(pixel_valid), .pixel_data(pixel_data), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_len(rd_len), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .underrun(underrun), .clr_underrun(clr_underrun)
  );

  typedef struct {logic [31:0] addr; logic [11:0] len;} burst_t;
  burst_t exp_q[$];
  int pix_q[$];
  bit line_avail[64];
  int n_cmp = 0, n_err = 0, gen = 0, ack_dly = 0, beat_gap = 0, beats = 0;
  bit mem_active = 0, in_data = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst(input int line);
    burst_t b;
    b.addr = 32'(fb_base + 32'(line * h));
    b.len = 12'(h);
    exp_q.push_back(b);
  endtask

  // Framebuffer: data word equals its own address; a line counts as delivered
  // only if its whole burst finished within the frame that requested it.
  task automatic serve();
    logic [31:0] a;
    int n, g, ln;
    a = rd_addr;
    n = int'(rd_len);
    g = gen;
    ln = int'(32'(a - fb_base) / 32'(n));
    mem_active = 1;
    beats = 0;
    for (int i = 0; i < ack_dly && rstn; i++) tick();
    if (rstn) begin
      rd_ack = 1;
      tick();
      rd_ack = 0;
    end
    in_data = rstn;
    for (int i = 0; i < n && rstn; i++) begin
      for (int j = 0; j < beat_gap && rstn; j++) tick();
      if (!rstn) break;
      rd_valid = 1;
      rd_data = 24'(a + 32'(i));
      tick();
      rd_valid = 0;
      beats++;
    end
    if (rstn && g == gen && ln < 64) line_avail[ln] = 1;
    in_data = 0;
    mem_active = 0;
    rd_valid = 0;
    rd_ack = 0;
  endtask

  initial begin
    rd_ack = 0;
    rd_valid = 0;
    rd_data = '0;
    forever begin
      tick();
      if (rstn && rd_req && !mem_active) serve();
    end
  end

  initial begin
    bit prev;
    burst_t cur;
    prev = 0;
    forever begin
      @(negedge clk);
      if (!rstn) prev = 0;
      else begin
        if (rd_req && !prev) begin
          chk("req_mem_idle", {31'b0, in_data}, 0);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_req: got addr 0x%0h, required no request at %0t", rd_addr, $time);
            cur.addr = rd_addr;
            cur.len = rd_len;
          end else begin
            cur = exp_q.pop_front();
            chk("rd_addr", rd_addr, cur.addr);
            chk("rd_len", {20'b0, rd_len}, {20'b0, cur.len});
          end
        end else if (rd_req) begin
          chk("rd_addr_hold", rd_addr, cur.addr);
          chk("rd_len_hold", {20'b0, rd_len}, {20'b0, cur.len});
        end
        prev = rd_req;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rstn && lcd_en) begin
      if (pix_q.size() == 0) bound_fail("pix_unexpected");
      else begin
        int p, r, c;
        p = pix_q.pop_front();
        r = p / 4096;
        c = p % 4096;
        chk("pixel_valid", {31'b0, pixel_valid}, {31'b0, line_avail[r]});
        if (line_avail[r]) chk("pixel_data", {8'b0, pixel_data}, {8'b0, 24'(fb_base + 32'(r * h + c))});
      end
    end
  end

  task automatic start_frame(input bit lat_chk);
    lcd_vs = 0;
    gen++;
    foreach (line_avail[i]) line_avail[i] = 0;
    push_burst(0);
    tick();
    if (lat_chk) chk("req_early", {31'b0, rd_req}, 0);
    tick();
    if (lat_chk) chk("req_latency", {31'b0, rd_req}, 1);
    tick();
    lcd_vs = 1;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || mem_active || rd_req) && t < 3000) begin
      tick();
      t++;
    end
    if (t >= 3000) bound_fail("idle_timeout");
    repeat (2) tick();
  endtask

  task automatic row(input int r);
    for (int c = 0; c < h; c++) begin
      lcd_en = 1;
      pixel_hpos = 12'(c);
      pixel_vpos = 12'(r);
      pix_q.push_back(r * 4096 + c);
      if (c == 0 && r + 1 < v) push_burst(r + 1);
      tick();
    end
    lcd_en = 0;
    repeat (4) tick();
  endtask

  task automatic rows(input int tight);
    for (int r = 0; r < v; r++) begin
      if (r != tight) wait_idle();
      row(r);
    end
    wait_idle();
  endtask

  task automatic wait_beats(input int n);
    int t;
    t = 0;
    while (!(in_data && beats >= n) && t < 2000) begin
      tick();
      t++;
    end
    if (t >= 2000) bound_fail("beat_wait");
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_req", {31'b0, rd_req}, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_rd_len", {20'b0, rd_len}, 0);
    chk("rst_pixel_valid", {31'b0, pixel_valid}, 0);
    chk("rst_pixel_data", {8'b0, pixel_data}, 0);
    chk("rst_underrun", {31'b0, underrun}, 0);
    rstn = 1;
    tick();
    start_frame(1);
    rows(-1);
    chk("underrun_basic", {31'b0, underrun}, 0);
    repeat (30) tick();
    ack_dly = 5;
    start_frame(1);
    rows(-1);
    ack_dly = 0;
    for (int f = 0; f < 4; f++) begin
      fb_base = (f == 0) ? 32'hFFFF_FFF8 : $urandom;
      h = $urandom_range(2, 24);
      v = $urandom_range(2, 6);
      ack_dly = $urandom_range(0, 3);
      beat_gap = $urandom_range(0, 2);
      start_frame(1);
      rows(-1);
      chk("underrun_rand", {31'b0, underrun}, 0);
    end
    fb_base = 32'h100;
    h = 8;
    v = 4;
    ack_dly = 0;
    beat_gap = 3;
    start_frame(1);
    rows(1);
    chk("underrun_slow", {31'b0, underrun}, 1);
    clr_underrun = 1;
    tick();
    clr_underrun = 0;
    chk("underrun_clr", {31'b0, underrun}, 0);
    start_frame(1);
    rows(1);
    chk("underrun_slow2", {31'b0, underrun}, 1);
    start_frame(1);
    wait_beats(3);
    rstn = 0;
    #1;
    chk("rstmid_rd_req", {31'b0, rd_req}, 0);
    chk("rstmid_rd_addr", rd_addr, 0);
    chk("rstmid_pixel_valid", {31'b0, pixel_valid}, 0);
    chk("rstmid_underrun", {31'b0, underrun}, 0);
    exp_q.delete();
    pix_q.delete();
    gen++;
    foreach (line_avail[i]) line_avail[i] = 0;
    tick();
    tick();
    rstn = 1;
    repeat (20) tick();
    beat_gap = 0;
    start_frame(1);
    rows(-1);
    fb_base = 32'h200;
    beat_gap = 3;
    start_frame(1);
    wait_idle();
    row(0);
    wait_beats(3);
    start_frame(0);
    rows(-1);
    beat_gap = 0;
    start_frame(1);
    rows(-1);
    repeat (10) tick();
    if (exp_q.size() != 0) bound_fail("bursts_outstanding");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end
endmodule
